seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
Parametrised N-digit multiplexed seven-segment display driver that generalises the fixed 6-digit scanner. It takes raw BCD/hex digits rather than pre-decoded segments and decodes them internally. Each display frame uses one snapshot of all inputs, so a frame never mixes old and new values. Adds per-digit enable, leading-zero blanking, anti-ghosting dead time and 16-level brightness PWM. Sits between the counter/time-keeping blocks and the board FND pins.

Parameters:
NUM_DIG, 6, number of digits scanned (2..8)
TICK_DIV, 50000, clk cycles per digit slot (> BLANK_CYC+16)
BLANK_CYC, 16, dead-time cycles at the start of each slot (>= 1)

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous, active-high reset
i_digit  input  4*NUM_DIG  digit codes; digit k = [4k+3:4k]; digit 0 = rightmost
i_dp  input  NUM_DIG  decimal point per digit, 1 = lit
i_dig_en  input  NUM_DIG  per-digit enable; 0 = digit always dark
i_lz_blank  input  1  leading-zero blanking enable
i_bright  input  4  brightness; 15 = full, 0 = 1/16 duty
o_seg  output  7  {a,b,c,d,e,f,g}, active-high
o_seg_dp  output  1  decimal point, active-high
o_seg_enb  output  NUM_DIG  common select, active-low, at most one bit low
o_frame  output  1  one-cycle pulse at end of each frame

Behaviour:
- Reset values: o_seg=0, o_seg_dp=0, o_seg_enb=all ones, o_frame=0, prescaler cnt=0, slot=0, snapshot=0.
- Prescaler cnt: counts 0..TICK_DIV-1 and wraps. slot advances at the wrap, going 0..NUM_DIG-1 and then back to 0.
- Frame wrap: cnt==TICK_DIV-1 and slot==NUM_DIG-1.
- Snapshot registers capture i_digit, i_dp, i_dig_en, i_lz_blank and i_bright:
  - on the frame-wrap cycle;
  - on the first cycle after rst deasserts.
  - They hold for the entire frame.
- o_frame: registered copy of frame wrap; 1 for exactly one cycle. It is not asserted for the post-reset capture.
- Leading-zero blanking (snapshot, i_lz_blank=1):
  - digit k>0 is blanked if it and all digits above it are 0x0;
  - digit 0 is never LZ-blanked;
  - a disabled digit (i_dig_en=0) still counts by its code value.
- Duty window:
  - L = ((TICK_DIV-BLANK_CYC)*(bright+1))>>4;
  - the slot is lit while BLANK_CYC <= cnt < BLANK_CYC+L.
- Pin outputs:
  - Lit (digit enabled and not LZ-blanked): o_seg_enb has bit slot low, o_seg = decode(code), o_seg_dp = dp bit.
  - Otherwise: enb all ones, seg=0, dp=0.
  - All outputs are registered: pins at cycle t+1 reflect cnt/slot at cycle t (latency 1).
- Decode: 0-9 use standard glyphs (0=1111110 ... 9=1110011). Codes 10-15 give 0000000 unless HEX_DIGIT_EN is defined.
- Dead time: enb is all ones for BLANK_CYC cycles at every slot change. No two enb bits are ever low together, including across frames.
- rst mid-frame: all state returns to reset values on the next edge. Pins go dark the cycle after rst is sampled high.
- Input changes mid-frame have no effect until the next frame.

Optional Feature:
- Macro: HEX_DIGIT_EN.
- Defined: codes 10-15 decode to A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. Leading-zero blanking still keys on 0x0 only.
- Undefined: codes 10-15 decode to 0000000 (digit dark but enb still driven). The decode logic for 10-15 is absent from the netlist.

Test Plan:
(All with NUM_DIG=4, TICK_DIV=40, BLANK_CYC=4.)
- Scan order and latency: i_digit=16'h1234, all enabled, bright=15, lz=0 → per slot: enb 4 cycles 1111, then 36 cycles lit; sequence 1110/"4"=0110011, 1101/"3", 1011/"2", 0111/"1"=0110000. o_frame pulses once every 160 cycles.
- Brightness: bright=0 → L=(36*1)>>4=2, so 2 lit cycles per slot. bright=7 → L=18.
- Leading-zero blanking: i_digit=16'h0070, lz=1 → digits 3 and 2 dark (enb stays 1111 in those slots), "7" and "0" shown. Same input with lz=0 → "0070". Input 16'h0000, lz=1 → only digit 0 shows "0".
- Frame coherence: change i_digit from 16'h1111 to 16'h2222 at slot 1, cnt 10 → remaining slots still show "1". "2" appears from the slot-0 window after the next o_frame.
- Hex/enable: i_digit=16'hABCD, i_dig_en=4'b1011 → slot 2 dark. With HEX_DIGIT_EN: D=0111101, C=1001110, A=1110111. Without the macro: seg=0000000 in every slot.
- Reset mid-operation: assert rst at slot 2, cnt 20 → the next cycle shows enb=1111, seg=0, o_frame=0. After release, the new frame starts at slot 0 with the snapshot taken on the first cycle after release.

Source files
------------

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: N-digit multiplexed seven-segment display driver.
// Takes raw 4-bit digit codes and decodes them internally. Each frame uses one
// snapshot of all inputs. Adds per-digit enable, leading-zero blanking,
// anti-ghosting dead time at every slot change and 16-level brightness PWM.
// Optional feature macro: HEX_DIGIT_EN (codes 10-15 decode to A,b,C,d,E,F;
// when undefined those codes decode to a dark glyph).
module seg_scan_mux #(
    parameter int NUM_DIG   = 6,
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NUM_DIG-1:0]   i_digit,
    input  logic [NUM_DIG-1:0]     i_dp,
    input  logic [NUM_DIG-1:0]     i_dig_en,
    input  logic                   i_lz_blank,
    input  logic [3:0]             i_bright,
    output logic [6:0]             o_seg,
    output logic                   o_seg_dp,
    output logic [NUM_DIG-1:0]     o_seg_enb,
    output logic                   o_frame
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int SW = $clog2(NUM_DIG);
    localparam logic [CW-1:0]      CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0]      SLOT_LAST = SW'(NUM_DIG - 1);
    localparam logic [31:0]        SPAN      = 32'(TICK_DIV - BLANK_CYC);
    localparam logic [31:0]        WIN_START = 32'(BLANK_CYC);
    localparam logic [NUM_DIG-1:0] SEL_ONE   = NUM_DIG'(1);

    logic [CW-1:0]        cnt;
    logic [SW-1:0]        slot;
    logic                 cap_pend;

    logic [4*NUM_DIG-1:0] snap_digit;
    logic [NUM_DIG-1:0]   snap_dp;
    logic [NUM_DIG-1:0]   snap_en;
    logic                 snap_lz;
    logic [3:0]           snap_bright;

    logic                 frame_wrap;
    logic [31:0]          lit_len;
    logic [31:0]          cnt_ext;
    logic                 in_window;
    logic                 lz_hide;
    logic                 slot_lit;
    logic [3:0]           cur_code;

    // Seven-segment glyph table, output order {a,b,c,d,e,f,g}
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 7'b1111110;
            4'h1:    decode = 7'b0110000;
            4'h2:    decode = 7'b1101101;
            4'h3:    decode = 7'b1111001;
            4'h4:    decode = 7'b0110011;
            4'h5:    decode = 7'b1011011;
            4'h6:    decode = 7'b1011111;
            4'h7:    decode = 7'b1110000;
            4'h8:    decode = 7'b1111111;
            4'h9:    decode = 7'b1110011;
`ifdef HEX_DIGIT_EN
            4'hA:    decode = 7'b1110111;
            4'hB:    decode = 7'b0011111;
            4'hC:    decode = 7'b1001110;
            4'hD:    decode = 7'b0111101;
            4'hE:    decode = 7'b1001111;
            4'hF:    decode = 7'b1000111;
`endif
            default: decode = 7'b0000000;
        endcase
    endfunction

    // The last cycle of the last slot closes the frame and triggers a new snapshot
    assign frame_wrap = (cnt == CNT_LAST) && (slot == SLOT_LAST);

    // Lit window length scales the post-dead-time span by (bright+1)/16
    assign lit_len   = (SPAN * (32'(snap_bright) + 32'd1)) >> 4;
    assign cnt_ext   = 32'(cnt);
    assign in_window = (cnt_ext >= WIN_START) && (cnt_ext < (WIN_START + lit_len));

    // A digit is a leading zero when it and every digit above it are zero
    assign cur_code  = snap_digit[{slot, 2'b00} +: 4];
    assign lz_hide   = snap_lz && (slot != '0) && ((snap_digit >> {slot, 2'b00}) == '0);
    assign slot_lit  = snap_en[slot] && !lz_hide && in_window;

    // Prescaler counts out one digit slot; the slot index advances when it wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            slot <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

    // Snapshot inputs on the first cycle out of reset and at every frame wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_pend    <= 1'b1;
            snap_digit  <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
            snap_lz     <= 1'b0;
            snap_bright <= '0;
        end else begin
            cap_pend <= 1'b0;
            if (cap_pend || frame_wrap) begin
                snap_digit  <= i_digit;
                snap_dp     <= i_dp;
                snap_en     <= i_dig_en;
                snap_lz     <= i_lz_blank;
                snap_bright <= i_bright;
            end
        end
    end

    // Registered pin drivers: one cycle behind the counter state they reflect
    always_ff @(posedge clk) begin
        if (rst) begin
            o_seg     <= '0;
            o_seg_dp  <= 1'b0;
            o_seg_enb <= '1;
            o_frame   <= 1'b0;
        end else begin
            o_frame <= frame_wrap;
            if (slot_lit) begin
                o_seg     <= decode(cur_code);
                o_seg_dp  <= snap_dp[slot];
                o_seg_enb <= ~(SEL_ONE << slot);
            end else begin
                o_seg     <= '0;
                o_seg_dp  <= 1'b0;
                o_seg_enb <= '1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: self-checking bench for seg_scan_mux (4 digits, 40-cycle
// slots, 4-cycle dead time). A frame-position model predicts every pin each
// cycle; directed scenarios pin down scan order, brightness, blanking,
// frame coherence, hex decode and mid-frame reset with literal values.
module tb_seg_scan_mux;

    localparam int ND    = 4;
    localparam int TD    = 40;
    localparam int BC    = 4;
    localparam int FRAME = ND * TD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_digit = '0;
    logic [3:0]  i_dp = '0;
    logic [3:0]  i_dig_en = '0;
    logic        i_lz_blank = 1'b0;
    logic [3:0]  i_bright = '0;
    logic [6:0]  o_seg;
    logic        o_seg_dp;
    logic [3:0]  o_seg_enb;
    logic        o_frame;

    int checks = 0;
    int errors = 0;

    seg_scan_mux #(.NUM_DIG(ND), .TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_digit    (i_digit),
        .i_dp       (i_dp),
        .i_dig_en   (i_dig_en),
        .i_lz_blank (i_lz_blank),
        .i_bright   (i_bright),
        .o_seg      (o_seg),
        .o_seg_dp   (o_seg_dp),
        .o_seg_enb  (o_seg_enb),
        .o_frame    (o_frame)
    );

    always #5 clk = ~clk;

    // Glyph table, {a,b,c,d,e,f,g}
    logic [6:0] glyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011,
`ifdef HEX_DIGIT_EN
        7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
`else
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
`endif
    };

    // Model state: position within the frame plus the frame's input snapshot
    int          m_pos, m_slot, m_cnt, m_len;
    bit          m_pend, m_lit, model_ready = 1'b0;
    logic [15:0] m_digit;
    logic [3:0]  m_dp, m_en, m_br, m_code;
    logic        m_lz;
    logic [6:0]  exp_seg = '0;
    logic        exp_dp = 1'b0;
    logic [3:0]  exp_enb = 4'hF;
    logic        exp_frame = 1'b0;

    int          slotLit [4];
    logic [6:0]  slotSeg [4];
    bit          slotMixed [4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] en,
                                 input logic lz, input logic [3:0] br);
        @(negedge clk);
        i_digit    = dig;
        i_dp       = dp;
        i_dig_en   = en;
        i_lz_blank = lz;
        i_bright   = br;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitFrame();
        int n = 0;
        bit seen = 0;
        while (!seen && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
            seen = (o_frame === 1'b1);
        end
        checkOutput("frame_seen", 32'(seen), 32'd1);
    endtask

    task automatic firstLit(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_seg_enb === 4'hF && n < 20);
    endtask

    // Record one full frame of pins starting right after a frame pulse
    task automatic measureFrame(input int changeAt, input logic [15:0] newDigit);
        int s;
        for (int k = 0; k < 4; k++) begin
            slotLit[k] = 0; slotSeg[k] = '0; slotMixed[k] = 0;
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            s = -1;
            for (int k = 0; k < 4; k++) if (o_seg_enb[k] === 1'b0) s = k;
            if (s >= 0) begin
                if (slotLit[s] > 0 && o_seg !== slotSeg[s]) slotMixed[s] = 1;
                slotLit[s]++;
                slotSeg[s] = o_seg;
            end
            if (i == changeAt) i_digit = newDigit;
        end
    endtask

    // Behavioural model: what the pins must show after each edge
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pos = 0; m_pend = 1; m_digit = '0; m_dp = '0; m_en = '0; m_lz = 0; m_br = '0;
                exp_seg = '0; exp_dp = 0; exp_enb = 4'hF; exp_frame = 0;
                model_ready = 1;
            end else begin
                m_slot = m_pos / TD;
                m_cnt  = m_pos % TD;
                m_len  = ((TD - BC) * (int'(m_br) + 1)) >> 4;
                m_code = 4'((m_digit >> (4 * m_slot)) & 16'hF);
                m_lit  = m_en[m_slot] && !(m_lz && m_slot > 0 && (m_digit >> (4 * m_slot)) == 16'h0)
                         && m_cnt >= BC && m_cnt < BC + m_len;
                exp_seg   = m_lit ? glyph[m_code] : 7'b0;
                exp_dp    = m_lit ? m_dp[m_slot] : 1'b0;
                exp_enb   = m_lit ? ~(4'b0001 << m_slot) : 4'hF;
                exp_frame = (m_pos == FRAME - 1);
                if (m_pend || m_pos == FRAME - 1) begin
                    m_digit = i_digit; m_dp = i_dp; m_en = i_dig_en; m_lz = i_lz_blank; m_br = i_bright;
                end
                m_pend = 0;
                m_pos  = (m_pos + 1) % FRAME;
            end
        end
    end

    // Per-cycle comparison of every pin against the model
    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                checkOutput("pins", {19'd0, o_frame, o_seg_enb, o_seg_dp, o_seg},
                            {19'd0, exp_frame, exp_enb, exp_dp, exp_seg});
                checkOutput("enb_single", 32'($countones(~o_seg_enb) <= 1), 32'd1);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        $display("[TB] start");
        applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0, 4'hF);
        tick(3);
        checkOutput("reset_pins", {o_frame, o_seg_enb, o_seg_dp, o_seg}, {1'b0, 4'hF, 1'b0, 7'b0});
        @(negedge clk);
        rst = 1'b0;
        firstLit(n);
        checkOutput("first_lit_latency", 32'(n), 32'd5);
        checkOutput("first_lit_pins", {o_seg_enb, o_seg}, {4'b1110, 7'b0110011});

        // Scan order, glyphs, full brightness, frame period
        waitFrame();
        measureFrame(-1, 16'h0);
        checkOutput("scan_lit0", 32'(slotLit[0]), 32'd36);
        checkOutput("scan_lit3", 32'(slotLit[3]), 32'd36);
        checkOutput("scan_seg0", 32'(slotSeg[0]), 32'b0110011);
        checkOutput("scan_seg1", 32'(slotSeg[1]), 32'b1111001);
        checkOutput("scan_seg2", 32'(slotSeg[2]), 32'b1101101);
        checkOutput("scan_seg3", 32'(slotSeg[3]), 32'b0110000);
        n = 0;
        do begin @(negedge clk); n++; end while (o_frame !== 1'b1 && n < 400);
        checkOutput("frame_period", 32'(n), 32'd160);

        // Brightness
        applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0, 4'h0);
        waitFrame();
        measureFrame(-1, 16'h0);
        checkOutput("bright0_lit", 32'(slotLit[1]), 32'd2);
        applyStimulus(16'h1234, 4'h5, 4'hF, 1'b0, 4'h7);
        waitFrame();
        measureFrame(-1, 16'h0);
        checkOutput("bright7_lit", 32'(slotLit[2]), 32'd18);

        // Leading-zero blanking
        applyStimulus(16'h0070, 4'h0, 4'hF, 1'b1, 4'hF);
        waitFrame();
        measureFrame(-1, 16'h0);
        checkOutput("lz_slot3_dark", 32'(slotLit[3]), 32'd0);
        checkOutput("lz_slot2_dark", 32'(slotLit[2]), 32'd0);
        checkOutput("lz_seg1", 32'(slotSeg[1]), 32'b1110000);
        checkOutput("lz_seg0", 32'(slotSeg[0]), 32'b1111110);
        applyStimulus(16'h0070, 4'h0, 4'hF, 1'b0, 4'hF);
        waitFrame();
        measureFrame(-1, 16'h0);
        checkOutput("nolz_seg3", 32'(slotSeg[3]), 32'b1111110);
        applyStimulus(16'h0000, 4'h0, 4'hF, 1'b1, 4'hF);
        waitFrame();
        measureFrame(-1, 16'h0);
        checkOutput("lz_zero_slot0", 32'(slotLit[0]), 32'd36);
        checkOutput("lz_zero_slot1", 32'(slotLit[1]), 32'd0);

        // Hex codes with a disabled digit
        applyStimulus(16'hABCD, 4'h1, 4'b1011, 1'b0, 4'hF);
        waitFrame();
        measureFrame(-1, 16'h0);
        checkOutput("hex_slot2_dark", 32'(slotLit[2]), 32'd0);
        checkOutput("hex_slot0_lit", 32'(slotLit[0]), 32'd36);
`ifdef HEX_DIGIT_EN
        checkOutput("hex_seg0", 32'(slotSeg[0]), 32'b0111101);
        checkOutput("hex_seg3", 32'(slotSeg[3]), 32'b1110111);
`else
        checkOutput("hex_seg0", 32'(slotSeg[0]), 32'b0);
        checkOutput("hex_seg3", 32'(slotSeg[3]), 32'b0);
`endif

        // Frame coherence: a mid-frame change waits for the next frame
        applyStimulus(16'h1111, 4'h0, 4'hF, 1'b0, 4'hF);
        waitFrame();
        measureFrame(50, 16'h2222);
        checkOutput("coh_old_seg3", {31'(slotSeg[3]), slotMixed[3]}, {31'b0110000, 1'b0});
        checkOutput("coh_old_seg1", {31'(slotSeg[1]), slotMixed[1]}, {31'b0110000, 1'b0});
        measureFrame(-1, 16'h0);
        checkOutput("coh_new_seg0", 32'(slotSeg[0]), 32'b1101101);

        // Reset mid-frame
        applyStimulus(16'h1234, 4'h0, 4'hF, 1'b0, 4'hF);
        waitFrame();
        tick(100);
        rst = 1'b1;
        tick(1);
        checkOutput("midrst_pins", {o_frame, o_seg_enb, o_seg_dp, o_seg}, {1'b0, 4'hF, 1'b0, 7'b0});
        tick(2);
        rst = 1'b0;
        firstLit(n);
        checkOutput("midrst_latency", 32'(n), 32'd5);
        checkOutput("midrst_slot0", 32'(o_seg_enb), 32'b1110);

        // Randomised phase: the model checks every cycle
        for (int r = 0; r < 40; r++) begin
            applyStimulus($urandom_range(0, 1) ? 16'($urandom) : (16'($urandom) & 16'h00F3),
                          4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 3));
                rst = 1'b0;
            end
            tick($urandom_range(1, 250));
        end
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
